// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S / left-justified transmit serializer
//
// Purpose: pops 32-bit left-aligned words from a TX FIFO and shifts them out
// on sd_o, one bit per falling edge of sck_i, framed by ws_i. Supports Philips
// I2S (1-bit delay) and left-justified framing, MSB- or LSB-first order,
// 8/16/24/32-bit data in 16/24/32-bit channels, and mono duplication.
//
// Ports:
//   clk_i, rst_n_i   system clock, asynchronous active-low reset
//   en_i             transmit enable
//   lsb_i            1 = LSB first, 0 = MSB first
//   fmt_i            00 = Philips I2S, 01/1x = left-justified
//   chl_i            channel length: 00 = 16, 01 = 24, 1x = 32 sck cycles
//   dtl_i            data length: 00 = 8, 01 = 16, 10 = 24, 11 = 32 bits
//   mono_i           1 = one word per frame, sent on both channels
//   sck_i, ws_i      serial clock and word select (synchronous to clk_i)
//   tx_valid_i       FIFO not empty
//   tx_ready_o       one-cycle pop strobe
//   tx_data_i        FIFO head word
//   sd_o             serial data out
//   busy_o           high in SYNC or RUN
//   underrun_o       one-cycle pulse when a channel load finds the FIFO empty

module i2s_tx_serializer (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        lsb_i,
  input  logic [1:0]  fmt_i,
  input  logic [1:0]  chl_i,
  input  logic [1:0]  dtl_i,
  input  logic        mono_i,
  input  logic        sck_i,
  input  logic        ws_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_data_i,
  output logic        sd_o,
  output logic        busy_o,
  output logic        underrun_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e      state_q, state_d;

  // Edge-detect registers
  logic        sck_q, sck_d;
  logic        sck_prev_q, sck_prev_d;
  logic        ws_q, ws_d;
  logic        ws_fe_q, ws_fe_d;      // ws as seen at the previous sck fall

  // Channel datapath
  logic [31:0] shift_q, shift_d;
  logic [31:0] left_word_q, left_word_d;  // last left word, replayed in mono
  logic [5:0]  cnt_q, cnt_d;               // bits already sent in this channel
  logic [5:0]  lim_q, lim_d;               // bits to send: min(data, channel)
  logic        lsb_q, lsb_d;
  logic        philips_q, philips_d;
  logic        pend_q, pend_d;             // Philips load due at the next fall
  logic        sd_q, sd_d;

  logic        fe;
  logic        ws_chg;
  logic        load;
  logic        load_right;
  logic        reuse;
  logic        pop;
  logic        und;
  logic [5:0]  n_cfg;
  logic [5:0]  l_cfg;
  logic [5:0]  lim_cfg;
  logic [31:0] load_word;
  logic [31:0] aligned;

  assign fe     = sck_prev_q & ~sck_q;
  assign ws_chg = fe & (ws_q != ws_fe_q);

  // Lengths from the live configuration; only latched when a load happens.
  always_comb begin
    n_cfg = 6'd32;
    l_cfg = 6'd32;
    unique case (dtl_i)
      2'b00:   n_cfg = 6'd8;
      2'b01:   n_cfg = 6'd16;
      2'b10:   n_cfg = 6'd24;
      default: n_cfg = 6'd32;
    endcase
    unique case (chl_i)
      2'b00:   l_cfg = 6'd16;
      2'b01:   l_cfg = 6'd24;
      default: l_cfg = 6'd32;
    endcase
    lim_cfg = (n_cfg < l_cfg) ? n_cfg : l_cfg;
  end

  always_comb begin
    state_d     = state_q;
    sck_d       = sck_i;
    sck_prev_d  = sck_q;
    ws_d        = ws_i;
    ws_fe_d     = fe ? ws_q : ws_fe_q;
    shift_d     = shift_q;
    left_word_d = left_word_q;
    cnt_d       = cnt_q;
    lim_d       = lim_q;
    lsb_d       = lsb_q;
    philips_d   = philips_q;
    pend_d      = pend_q;
    sd_d        = sd_q;
    load        = 1'b0;
    load_right  = 1'b0;
    reuse       = 1'b0;
    pop         = 1'b0;
    und         = 1'b0;
    load_word   = 32'd0;
    aligned     = 32'd0;

    unique case (state_q)
      ST_IDLE: begin
        sd_d   = 1'b0;
        pend_d = 1'b0;
        if (en_i) begin
          state_d = ST_SYNC;
        end
      end

      ST_SYNC: begin
        sd_d   = 1'b0;
        pend_d = 1'b0;
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (ws_chg && !ws_q) begin
          // First change into the left channel opens the stream.
          state_d   = ST_RUN;
          philips_d = (fmt_i == 2'b00);
          if (fmt_i == 2'b00) begin
            pend_d = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (fe) begin
          // Default per-fall action: emit the next bit of the current channel.
          // In Philips mode this also covers the fall where ws changes, which
          // still carries the last bit of the previous channel.
          sd_d    = (cnt_q < lim_q) ? (lsb_q ? shift_q[0] : shift_q[31]) : 1'b0;
          shift_d = lsb_q ? (shift_q >> 1) : (shift_q << 1);
          cnt_d   = (cnt_q == 6'd32) ? cnt_q : cnt_q + 6'd1;

          if (ws_chg && !en_i) begin
            state_d = ST_IDLE;
            sd_d    = 1'b0;
            pend_d  = 1'b0;
          end else if (pend_q) begin
            // The pending load belongs to the channel ws entered one fall ago.
            load       = 1'b1;
            load_right = ws_fe_q;
            pend_d     = ws_chg;
          end else if (ws_chg) begin
            if (philips_q) begin
              pend_d = 1'b1;
            end else begin
              load       = 1'b1;
              load_right = ws_q;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      reuse     = load_right & mono_i;
      pop       = ~reuse & tx_valid_i;
      und       = ~reuse & ~tx_valid_i;
      load_word = reuse ? left_word_q : (tx_valid_i ? tx_data_i : 32'd0);
      // LSB-first starts at bit 32-N, so bring that bit down to position 0.
      aligned   = lsb_i ? (load_word >> (6'd32 - n_cfg)) : load_word;
      if (!load_right) begin
        left_word_d = load_word;
      end
      sd_d      = lsb_i ? aligned[0] : aligned[31];
      shift_d   = lsb_i ? (aligned >> 1) : (aligned << 1);
      cnt_d     = 6'd1;
      lim_d     = lim_cfg;
      lsb_d     = lsb_i;
      philips_d = (fmt_i == 2'b00);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      sck_q       <= 1'b0;
      sck_prev_q  <= 1'b0;
      ws_q        <= 1'b0;
      ws_fe_q     <= 1'b0;
      shift_q     <= 32'd0;
      left_word_q <= 32'd0;
      cnt_q       <= 6'd0;
      lim_q       <= 6'd0;
      lsb_q       <= 1'b0;
      philips_q   <= 1'b0;
      pend_q      <= 1'b0;
      sd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_q       <= sck_d;
      sck_prev_q  <= sck_prev_d;
      ws_q        <= ws_d;
      ws_fe_q     <= ws_fe_d;
      shift_q     <= shift_d;
      left_word_q <= left_word_d;
      cnt_q       <= cnt_d;
      lim_q       <= lim_d;
      lsb_q       <= lsb_d;
      philips_q   <= philips_d;
      pend_q      <= pend_d;
      sd_q        <= sd_d;
    end
  end

  // Strobes are combinational so they align with the load cycle and can
  // never assert without tx_valid_i.
  assign tx_ready_o = pop;
  assign underrun_o = und;
  assign sd_o       = sd_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - self-checking bench for i2s_tx_serializer

module tb_i2s_tx_serializer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        en_i;
  logic        lsb_i;
  logic [1:0]  fmt_i;
  logic [1:0]  chl_i;
  logic [1:0]  dtl_i;
  logic        mono_i;
  logic        sck_i;
  logic        ws_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [31:0] tx_data_i;
  logic        sd_o;
  logic        busy_o;
  logic        underrun_o;

  i2s_tx_serializer dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .lsb_i      (lsb_i),
    .fmt_i      (fmt_i),
    .chl_i      (chl_i),
    .dtl_i      (dtl_i),
    .mono_i     (mono_i),
    .sck_i      (sck_i),
    .ws_i       (ws_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .tx_data_i  (tx_data_i),
    .sd_o       (sd_o),
    .busy_o     (busy_o),
    .underrun_o (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fifo[$];
  logic        rec_sd[512];
  logic        rec_pop[512];
  logic        rec_und[512];
  logic        rec_busy[512];
  int          n_rec;

  typedef struct {
    logic [1:0]  fmt;
    logic        lsb;
    logic [1:0]  dtl;
    logic [1:0]  chl;
    logic [31:0] wl;
    logic [31:0] wr;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic refresh_fifo();
    tx_valid_i = (fifo.size() != 0);
    tx_data_i  = (fifo.size() != 0) ? fifo[0] : 32'd0;
  endtask

  function automatic int chan_len(input logic [1:0] c);
    return (c == 2'b00) ? 16 : (c == 2'b01) ? 24 : 32;
  endfunction

  // One sck period; ws changes together with the falling edge.
  task automatic fe_step(input logic ws_val);
    logic p, u;
    sck_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    sck_i = 1'b0;
    ws_i  = ws_val;
    @(posedge clk_i);
    #1;
    p = tx_ready_o;
    u = underrun_o;
    check("ready_needs_valid", {31'd0, p & ~tx_valid_i}, 32'd0);
    @(posedge clk_i);
    #1;
    if (p && fifo.size() > 0) void'(fifo.pop_front());
    refresh_fifo();
    if (n_rec < 512) begin
      rec_sd[n_rec]   = sd_o;
      rec_pop[n_rec]  = p;
      rec_und[n_rec]  = u;
      rec_busy[n_rec] = busy_o;
      n_rec++;
    end
  endtask

  task automatic run_ws(input int count, input logic ws_val);
    for (int i = 0; i < count; i++) fe_step(ws_val);
  endtask

  function automatic logic [31:0] get_bits(input int start, input int len);
    logic [31:0] v;
    v = 32'd0;
    for (int j = 0; j < len; j++) v[31-j] = rec_sd[start+j];
    return v;
  endfunction

  // sel: 0 = pops, 1 = underruns, 2 = sd ones
  function automatic int count_sig(input int sel, input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i < hi; i++) begin
      if (sel == 0 && rec_pop[i]) c++;
      if (sel == 1 && rec_und[i]) c++;
      if (sel == 2 && rec_sd[i]) c++;
    end
    return c;
  endfunction

  task automatic do_reset(input logic chk);
    rst_n_i = 1'b0;
    en_i    = 1'b0;
    sck_i   = 1'b1;
    ws_i    = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    if (chk) begin
      check("rst_sd", {31'd0, sd_o}, 32'd0);
      check("rst_ready", {31'd0, tx_ready_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_underrun", {31'd0, underrun_o}, 32'd0);
    end
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    n_rec = 0;
  endtask

  task automatic cfg(input logic [1:0] f, input logic l, input logic [1:0] d,
                     input logic [1:0] c, input logic m);
    fmt_i  = f;
    lsb_i  = l;
    dtl_i  = d;
    chl_i  = c;
    mono_i = m;
  endtask

  initial begin
    int          L, d, S, F, N, T, exp_pops, exp_und, bad_idx;
    logic        exp_b, got_b;
    logic [31:0] w;
    logic [31:0] words[6];

    tbl[0] = '{2'b00, 1'b0, 2'b11, 2'b10, 32'hA5000000, 32'h3C000000, 32'hA5000000, 32'h3C000000};
    tbl[1] = '{2'b01, 1'b1, 2'b01, 2'b00, 32'h12340000, 32'h12340000, 32'h2C480000, 32'h2C480000};
    tbl[2] = '{2'b01, 1'b0, 2'b11, 2'b00, 32'hDEADBEEF, 32'h0F0F1234, 32'hDEAD0000, 32'h0F0F0000};
    tbl[3] = '{2'b00, 1'b1, 2'b00, 2'b00, 32'hA1FFFFFF, 32'hA1FFFFFF, 32'h85000000, 32'h85000000};
    tbl[4] = '{2'b00, 1'b1, 2'b10, 2'b01, 32'h123456FF, 32'h80000000, 32'h6A2C4800, 32'h00000100};
    tbl[5] = '{2'b01, 1'b0, 2'b10, 2'b10, 32'hFFFFFF77, 32'h000001FF, 32'hFFFFFF00, 32'h00000100};

    cfg(2'b00, 1'b0, 2'b11, 2'b10, 1'b0);
    fifo.delete();
    fifo.push_back(32'hFFFFFFFF);
    refresh_fifo();
    n_rec = 0;
    do_reset(1'b1);

    // Table of single-frame vectors
    for (int r = 0; r < 6; r++) begin
      L = chan_len(tbl[r].chl);
      d = (tbl[r].fmt == 2'b00) ? 1 : 0;
      do_reset(1'b0);
      cfg(tbl[r].fmt, tbl[r].lsb, tbl[r].dtl, tbl[r].chl, 1'b0);
      fifo.delete();
      fifo.push_back(tbl[r].wl);
      fifo.push_back(tbl[r].wr);
      refresh_fifo();
      en_i = 1'b1;
      run_ws(4, 1'b1);
      run_ws(L, 1'b0);
      run_ws(L, 1'b1);
      run_ws(1, 1'b0);
      check($sformatf("tbl%0d_left", r), get_bits(4 + d, L), tbl[r].el);
      check($sformatf("tbl%0d_right", r), get_bits(4 + L + d, L), tbl[r].er);
      check($sformatf("tbl%0d_pops", r), count_sig(0, 0, n_rec), 2);
      check($sformatf("tbl%0d_underrun", r), count_sig(1, 0, 4 + 2 * L), 0);
      check($sformatf("tbl%0d_busy", r), {31'd0, rec_busy[4]}, 32'd1);
    end

    // Underrun at a left load, then normal pop once data appears
    do_reset(1'b0);
    cfg(2'b01, 1'b0, 2'b11, 2'b00, 1'b0);
    fifo.delete();
    refresh_fifo();
    en_i = 1'b1;
    run_ws(4, 1'b1);
    run_ws(16, 1'b0);
    fifo.push_back(32'hF0F00000);
    refresh_fifo();
    run_ws(16, 1'b1);
    check("und_pulse_at_load", {31'd0, rec_und[4]}, 32'd1);
    check("und_count", count_sig(1, 0, n_rec), 1);
    check("und_left_zero", get_bits(4, 16), 32'd0);
    check("und_left_pops", count_sig(0, 0, 20), 0);
    check("und_right_data", get_bits(20, 16), 32'hF0F00000);
    check("und_total_pops", count_sig(0, 0, n_rec), 1);

    // Mono: one pop per frame, word repeated on both channels
    do_reset(1'b0);
    cfg(2'b01, 1'b0, 2'b00, 2'b00, 1'b1);
    fifo.delete();
    fifo.push_back(32'h11ABCDEF);
    fifo.push_back(32'h22FFFFFF);
    refresh_fifo();
    en_i = 1'b1;
    run_ws(4, 1'b1);
    run_ws(16, 1'b0);
    run_ws(16, 1'b1);
    run_ws(16, 1'b0);
    run_ws(16, 1'b1);
    check("mono_l1", get_bits(4, 16), 32'h11000000);
    check("mono_r1", get_bits(20, 16), 32'h11000000);
    check("mono_l2", get_bits(36, 16), 32'h22000000);
    check("mono_r2", get_bits(52, 16), 32'h22000000);
    check("mono_pops_f1", count_sig(0, 4, 36), 1);
    check("mono_pops_f2", count_sig(0, 36, 68), 1);

    // Stop: en dropped mid-left channel
    do_reset(1'b0);
    cfg(2'b01, 1'b0, 2'b11, 2'b00, 1'b0);
    fifo.delete();
    fifo.push_back(32'hABCD0000);
    fifo.push_back(32'h11110000);
    fifo.push_back(32'h22220000);
    refresh_fifo();
    en_i = 1'b1;
    run_ws(4, 1'b1);
    run_ws(8, 1'b0);
    en_i = 1'b0;
    run_ws(8, 1'b0);
    run_ws(4, 1'b1);
    run_ws(4, 1'b0);
    check("stop_left_completes", get_bits(4, 16), 32'hABCD0000);
    check("stop_busy_before", {31'd0, rec_busy[19]}, 32'd1);
    check("stop_busy_after", {31'd0, rec_busy[20]}, 32'd0);
    check("stop_sd_zero", count_sig(2, 20, 28), 0);
    check("stop_pops", count_sig(0, 0, n_rec), 1);
    check("stop_fifo_left", fifo.size(), 2);

    // Reset mid-channel, then resync before any data
    do_reset(1'b0);
    cfg(2'b00, 1'b0, 2'b11, 2'b10, 1'b0);
    fifo.delete();
    fifo.push_back(32'hFFFFFFFF);
    fifo.push_back(32'hFFFFFFFF);
    refresh_fifo();
    en_i = 1'b1;
    run_ws(4, 1'b1);
    run_ws(6, 1'b0);
    check("rstmid_pre_sd", {31'd0, rec_sd[9]}, 32'd1);
    rst_n_i = 1'b0;
    #2;
    check("rstmid_sd", {31'd0, sd_o}, 32'd0);
    check("rstmid_busy", {31'd0, busy_o}, 32'd0);
    check("rstmid_ready", {31'd0, tx_ready_o}, 32'd0);
    check("rstmid_underrun", {31'd0, underrun_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    n_rec = 0;
    run_ws(4, 1'b0);
    run_ws(4, 1'b1);
    check("rstmid_resync_busy", {31'd0, rec_busy[0]}, 32'd1);
    check("rstmid_no_pop_sync", count_sig(0, 0, 8), 0);
    check("rstmid_sd_sync", count_sig(2, 0, 8), 0);
    run_ws(3, 1'b0);
    check("rstmid_pop_after", count_sig(0, 8, 11), 1);
    check("rstmid_first_bit", {31'd0, rec_sd[9]}, 32'd1);

    // Randomized frames against a channel-level reference model
    for (int t = 0; t < 16; t++) begin
      do_reset(1'b0);
      cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      L = chan_len(chl_i);
      d = (fmt_i == 2'b00) ? 1 : 0;
      N = 8 * (int'(dtl_i) + 1);
      S = $urandom_range(2, 5);
      F = $urandom_range(2, 3);
      fifo.delete();
      for (int k = 0; k < 6; k++) words[k] = $urandom;
      for (int k = 0; k < (mono_i ? F : 2 * F); k++) fifo.push_back(words[k]);
      refresh_fifo();
      en_i = 1'b1;
      run_ws(S, 1'b1);
      for (int f = 0; f < F; f++) begin
        run_ws(L, 1'b0);
        run_ws(L, 1'b1);
      end
      run_ws(1, 1'b0);
      T = S + 2 * F * L + 1;

      // Channel k starts loading at S + k*L (+1 for Philips).
      exp_pops = 0;
      exp_und  = 0;
      for (int k = 0; k <= 2 * F; k++) begin
        if (S + k * L + d < T && (!mono_i || k % 2 == 0)) begin
          if ((mono_i ? k / 2 : k) < (mono_i ? F : 2 * F)) exp_pops++;
          else exp_und++;
        end
      end
      bad_idx = -1;
      for (int i = 0; i < T; i++) begin
        exp_b = 1'b0;
        for (int k = 0; k <= 2 * F; k++) begin
          if (S + k * L + d <= i) begin
            int j, widx;
            j    = i - (S + k * L + d);
            widx = mono_i ? k / 2 : k;
            w    = (widx < (mono_i ? F : 2 * F)) ? words[widx] : 32'd0;
            exp_b = (j < N) ? (lsb_i ? w[32 - N + j] : w[31 - j]) : 1'b0;
          end
        end
        got_b = rec_sd[i];
        if (got_b !== exp_b && bad_idx < 0) bad_idx = i;
      end
      check($sformatf("rand%0d_sd_first_bad_idx(f%0d l%0d d%0d c%0d m%0d)", t, fmt_i, lsb_i,
                      dtl_i, chl_i, mono_i), bad_idx, -1);
      check($sformatf("rand%0d_pops", t), count_sig(0, 0, T), exp_pops);
      check($sformatf("rand%0d_underruns", t), count_sig(1, 0, T), exp_und);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
